// File: rtl/sh7604_divu_arb.sv
// Two-master arbiter for the SH7604 DIVU window: a parked grant, locked from division start to result read.
// The owner path is combinational (zero latency); a non-owner in the window stalls until it is granted.
module sh7604_divu_arb #(
  parameter logic [31:0] BASE_ADDR = 32'hFFFFFF00,
  parameter logic [6:0]  LOCK_TO   = 7'd80
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE_R,
  input  logic        CE_F,
  input  logic        EN,
  input  logic        RES_N,
  input  logic [31:0] M0_A,
  input  logic [31:0] M0_DI,
  input  logic [3:0]  M0_BA,
  input  logic        M0_WE,
  input  logic        M0_REQ,
  output logic [31:0] M0_DO,
  output logic        M0_BUSY,
  input  logic [31:0] M1_A,
  input  logic [31:0] M1_DI,
  input  logic [3:0]  M1_BA,
  input  logic        M1_WE,
  input  logic        M1_REQ,
  output logic [31:0] M1_DO,
  output logic        M1_BUSY,
  output logic [31:0] S_A,
  output logic [31:0] S_DI,
  output logic [3:0]  S_BA,
  output logic        S_WE,
  output logic        S_REQ,
  input  logic [31:0] S_DO,
  input  logic        S_BUSY,
  output logic        OWNER,
  output logic        LOCKED
);

  logic        owner_q, owner_d;
  logic        locked_q, locked_d;
  logic [6:0]  cnt_q, cnt_d;

  logic        win0, win1, win_own, win_oth;
  logic [31:0] own_a, own_di;
  logic [3:0]  own_ba;
  logic        own_we;
  logic [2:0]  own_word;
  logic        lock_set, rel_rd, rel_to, tick;
  logic        unused_ce_f;

  assign unused_ce_f = CE_F;

  always_comb begin
    win0     = M0_REQ && (M0_A[31:5] == BASE_ADDR[31:5]);
    win1     = M1_REQ && (M1_A[31:5] == BASE_ADDR[31:5]);
    win_own  = owner_q ? win1 : win0;
    win_oth  = owner_q ? win0 : win1;
    own_a    = owner_q ? M1_A  : M0_A;
    own_di   = owner_q ? M1_DI : M0_DI;
    own_ba   = owner_q ? M1_BA : M0_BA;
    own_we   = owner_q ? M1_WE : M0_WE;
    own_word = own_a[4:2];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      owner_q  <= 1'b0;
      locked_q <= 1'b0;
      cnt_q    <= 7'd0;
    end else begin
      owner_q  <= owner_d;
      locked_q <= locked_d;
      cnt_q    <= cnt_d;
    end
  end

  // Release is resolved before the grant switch so a timed-out lock can hand over in the same cycle.
  always_comb begin
    owner_d  = owner_q;
    locked_d = locked_q;
    cnt_d    = cnt_q;
    lock_set = win_own && own_we && !S_BUSY && (own_word == 3'd1 || own_word == 3'd5);
    rel_rd   = win_own && !own_we && !S_BUSY &&
               (own_word == 3'd1 || own_word == 3'd5 || own_word == 3'd7);
    tick     = EN && locked_q;
    rel_to   = tick && (cnt_q == LOCK_TO - 7'd1);
    if (CE_R) begin
      if (!RES_N) begin
        owner_d  = 1'b0;
        locked_d = 1'b0;
        cnt_d    = 7'd0;
      end else begin
        if (tick && (cnt_q != LOCK_TO - 7'd1)) cnt_d = cnt_q + 7'd1;
        if (rel_rd || rel_to) locked_d = 1'b0;
        if (lock_set) begin
          locked_d = 1'b1;
          cnt_d    = 7'd0;
        end
        if (!locked_d && !win_own && win_oth) owner_d = ~owner_q;
      end
    end
  end

  // Outputs are forced quiet while the async reset is held, even if masters keep requesting.
  always_comb begin
    S_A     = RST_N ? own_a  : 32'd0;
    S_DI    = RST_N ? own_di : 32'd0;
    S_BA    = RST_N ? own_ba : 4'd0;
    S_WE    = RST_N && own_we;
    S_REQ   = RST_N && win_own;
    M0_DO   = (RST_N && !owner_q && win0) ? S_DO : 32'd0;
    M1_DO   = (RST_N &&  owner_q && win1) ? S_DO : 32'd0;
    M0_BUSY = RST_N && win0 && (owner_q || S_BUSY);
    M1_BUSY = RST_N && win1 && (!owner_q || S_BUSY);
    OWNER   = owner_q;
    LOCKED  = locked_q;
  end

endmodule

// File: tb/tb_sh7604_divu_arb.sv
// Bench for sh7604_divu_arb: directed cycle table, lock-timeout and reset sequences, then random traffic vs a model.
module tb_sh7604_divu_arb;

  localparam logic [31:0] B = 32'hFFFFFF00;

  logic        CLK = 1'b0;
  logic        RST_N, CE_R, CE_F, EN, RES_N;
  logic [31:0] M0_A, M0_DI, M1_A, M1_DI, M0_DO, M1_DO;
  logic [3:0]  M0_BA, M1_BA, S_BA;
  logic        M0_WE, M0_REQ, M1_WE, M1_REQ, M0_BUSY, M1_BUSY;
  logic [31:0] S_A, S_DI, S_DO;
  logic        S_WE, S_REQ, S_BUSY, OWNER, LOCKED;

  logic        use_divu;
  logic [31:0] rnd_do, divu_rd;
  logic [31:0] dv [8];

  int n_chk = 0;
  int n_pass = 0;

  sh7604_divu_arb dut (
    .CLK(CLK), .RST_N(RST_N), .CE_R(CE_R), .CE_F(CE_F), .EN(EN), .RES_N(RES_N),
    .M0_A(M0_A), .M0_DI(M0_DI), .M0_BA(M0_BA), .M0_WE(M0_WE), .M0_REQ(M0_REQ),
    .M0_DO(M0_DO), .M0_BUSY(M0_BUSY),
    .M1_A(M1_A), .M1_DI(M1_DI), .M1_BA(M1_BA), .M1_WE(M1_WE), .M1_REQ(M1_REQ),
    .M1_DO(M1_DO), .M1_BUSY(M1_BUSY),
    .S_A(S_A), .S_DI(S_DI), .S_BA(S_BA), .S_WE(S_WE), .S_REQ(S_REQ),
    .S_DO(S_DO), .S_BUSY(S_BUSY), .OWNER(OWNER), .LOCKED(LOCKED)
  );

  always #5 CLK = ~CLK;

  // Tiny DIVU: quotient lands in 04/14, remainder in 10, whenever 04 or 14 is written.
  assign divu_rd = (S_REQ && !S_WE) ? dv[S_A[4:2]] : 32'd0;
  assign S_DO    = use_divu ? divu_rd : rnd_do;

  always @(posedge CLK) begin
    if (use_divu && S_REQ && S_WE && !S_BUSY) begin
      dv[S_A[4:2]] <= S_DI;
      if ((S_A[4:2] == 3'd1 || S_A[4:2] == 3'd5) && dv[0] != 32'd0) begin
        dv[1] <= S_DI / dv[0];
        dv[5] <= S_DI / dv[0];
        dv[4] <= S_DI % dv[0];
      end
    end
  end

  task automatic check(input string nm, input logic [137:0] act, input logic [137:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [137:0] all_outs();
    return {S_A, S_DI, S_BA, S_WE, S_REQ, M0_DO, M0_BUSY, M1_DO, M1_BUSY, OWNER, LOCKED};
  endfunction

  task automatic m0(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    M0_REQ = r; M0_WE = w; M0_A = a; M0_DI = d; M0_BA = 4'hF;
  endtask

  task automatic m1(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    M1_REQ = r; M1_WE = w; M1_A = a; M1_DI = d; M1_BA = 4'hF;
  endtask

  typedef struct {
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        ce, sb;
    logic [4:0]  eflg;   // {OWNER, LOCKED, M0_BUSY, M1_BUSY, S_REQ}
    logic [31:0] esa, edo;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
                              logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
                              logic ce, logic sb, logic [4:0] eflg, logic [31:0] esa, logic [31:0] edo);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.ce = ce; v.sb = sb; v.eflg = eflg; v.esa = esa; v.edo = edo;
    return v;
  endfunction

  function automatic logic [31:0] raddr(bit quiet);
    int r;
    logic [31:0] off;
    r = $urandom_range(0, 19);
    if (r < 16) begin
      if (quiet) begin
        case (r % 5)
          0: off = 32'h00;
          1: off = 32'h08;
          2: off = 32'h0C;
          3: off = 32'h10;
          default: off = 32'h18;
        endcase
      end else off = 32'(4 * (r % 8));
      return B + off;
    end
    case (r)
      16: return 32'hFFFFFE10;
      17: return 32'hFFFFFF20;
      18: return 32'hFFFFFEFC;
      default: return 32'h00000004;
    endcase
  endfunction

  function automatic bit in_win(logic req, logic [31:0] a);
    return req && (a >= B) && (a <= B + 32'd31);
  endfunction

  bit m_owner, m_locked;
  int m_budget;

  initial begin
    int en_cnt;
    bit got;
    for (int i = 0; i < 8; i++) dv[i] = 32'd0;
    use_divu = 1'b1; rnd_do = 32'd0;
    RST_N = 1'b0; CE_R = 1'b1; CE_F = 1'b0; EN = 1'b1; RES_N = 1'b1; S_BUSY = 1'b0;
    m0(0, 0, 0, 0); m1(0, 0, 0, 0);
    repeat (2) @(posedge CLK);
    #1 check("reset_state", all_outs(), 138'd0);
    @(negedge CLK) RST_N = 1'b1;

    tbl.push_back(mk(0,0,0,0,         0,0,0,0,       1,0, 5'b00000, 0, 0));
    tbl.push_back(mk(1,1,B,3,         0,0,0,0,       1,0, 5'b00001, B, 0));
    tbl.push_back(mk(1,1,B+4,100,     0,0,0,0,       1,0, 5'b00001, B+4, 0));
    tbl.push_back(mk(1,0,B+4,0,       0,0,0,0,       1,0, 5'b01001, B+4, 33));
    tbl.push_back(mk(0,0,0,0,         0,0,0,0,       1,0, 5'b00000, 0, 0));
    tbl.push_back(mk(1,1,B,7,         0,0,0,0,       1,0, 5'b00001, B, 0));
    tbl.push_back(mk(1,1,B+20,70,     0,0,0,0,       1,0, 5'b00001, B+20, 0));
    tbl.push_back(mk(0,0,0,0,         1,1,B,5,       1,0, 5'b01010, 0, 0));
    tbl.push_back(mk(0,0,0,0,         1,1,B,5,       1,0, 5'b01010, 0, 0));
    tbl.push_back(mk(1,0,B+20,0,      1,1,B,5,       1,0, 5'b01011, B+20, 10));
    tbl.push_back(mk(0,0,0,0,         1,1,B,5,       1,0, 5'b00010, 0, 0));
    tbl.push_back(mk(0,0,0,0,         1,1,B,5,       1,0, 5'b10001, B, 0));
    tbl.push_back(mk(1,0,B,0,         0,0,0,0,       1,0, 5'b10100, 0, 0));
    tbl.push_back(mk(1,0,B,0,         1,0,B+8,0,     1,0, 5'b00011, B, 5));
    tbl.push_back(mk(0,0,0,0,         1,0,B+8,0,     1,0, 5'b00010, 0, 0));
    tbl.push_back(mk(0,0,0,0,         1,0,B+8,0,     1,0, 5'b10001, B+8, 0));
    tbl.push_back(mk(1,0,32'hFFFFFE10,0, 0,0,0,0,    1,0, 5'b10000, 0, 0));
    tbl.push_back(mk(0,0,0,0,         0,0,0,0,       1,0, 5'b10000, 0, 0));
    tbl.push_back(mk(1,0,B,0,         0,0,0,0,       0,0, 5'b10100, 0, 0));
    tbl.push_back(mk(1,0,B,0,         0,0,0,0,       0,0, 5'b10100, 0, 0));
    tbl.push_back(mk(1,0,B,0,         0,0,0,0,       1,0, 5'b10100, 0, 0));
    tbl.push_back(mk(1,0,B,0,         0,0,0,0,       1,0, 5'b00001, B, 5));
    tbl.push_back(mk(1,0,B,0,         0,0,0,0,       1,1, 5'b00101, B, 5));

    foreach (tbl[i]) begin
      @(negedge CLK);
      m0(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0);
      m1(tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      CE_R = tbl[i].ce; S_BUSY = tbl[i].sb;
      #1 check($sformatf("vec%0d", i),
               {OWNER, LOCKED, M0_BUSY, M1_BUSY, S_REQ, S_A, M0_DO},
               {tbl[i].eflg, tbl[i].esa, tbl[i].edo});
    end

    // Abandoned division: M1 locks, never reads; EN held low for the first 10 cycles.
    @(negedge CLK);
    CE_R = 1'b1; S_BUSY = 1'b0;
    m0(0, 0, 0, 0); m1(1, 1, B+20, 9);
    @(negedge CLK);
    @(negedge CLK);
    #1 check("to_locked", {OWNER, LOCKED}, 2'b11);
    m1(0, 0, 0, 0); m0(1, 0, B, 0);
    en_cnt = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      EN = (i < 10) ? 1'b0 : 1'b1;
      @(posedge CLK);
      en_cnt += int'(EN);
      @(negedge CLK);
      #1 if (!LOCKED) got = 1;
    end
    check("to_en_cycles", got ? en_cnt : 999, 80);
    check("to_handover", {OWNER, M0_BUSY, LOCKED}, 3'b000);

    // Async reset while M1 owns and holds the lock.
    m0(0, 0, 0, 0); m1(1, 1, B+4, 50);
    @(negedge CLK);
    @(negedge CLK);
    #1 check("rst_pre", {OWNER, LOCKED}, 2'b11);
    m0(1, 0, B, 0);
    #2 RST_N = 1'b0;
    #1 check("rst_outs_now", all_outs(), 138'd0);
    @(posedge CLK);
    #1 check("rst_outs_held", all_outs(), 138'd0);
    @(negedge CLK);
    RST_N = 1'b1; m0(0, 0, 0, 0); m1(0, 0, 0, 0);

    // Soft reset takes effect only on CE_R.
    @(negedge CLK) m0(1, 1, B+4, 1);
    @(negedge CLK);
    #1 check("res_locked", {OWNER, LOCKED}, 2'b01);
    RES_N = 1'b0; CE_R = 1'b0;
    @(negedge CLK);
    #1 check("res_no_ce", {OWNER, LOCKED}, 2'b01);
    CE_R = 1'b1;
    @(negedge CLK);
    #1 check("res_ce", {OWNER, LOCKED}, 2'b00);
    RES_N = 1'b1; m0(0, 0, 0, 0);

    // Random traffic against the rule-level model.
    use_divu = 1'b0;
    m_owner = 0; m_locked = 0; m_budget = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      bit quiet, w0, w1, wo, woth, owe, done, setl, rel;
      logic [31:0] oa, odi;
      logic [3:0] oba;
      int off;
      logic [137:0] exp;
      @(negedge CLK);
      quiet = ((cyc / 400) % 2) == 1;
      m0($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, raddr(quiet), $urandom);
      m1($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, raddr(quiet), $urandom);
      M0_BA = 4'($urandom); M1_BA = 4'($urandom);
      EN = $urandom_range(0, 9) < 8; CE_R = $urandom_range(0, 19) < 17;
      CE_F = ~CE_R; RES_N = $urandom_range(0, 99) > 1;
      S_BUSY = $urandom_range(0, 3) == 0; rnd_do = $urandom;
      #1;
      w0 = in_win(M0_REQ, M0_A); w1 = in_win(M1_REQ, M1_A);
      wo = m_owner ? w1 : w0; woth = m_owner ? w0 : w1;
      oa = m_owner ? M1_A : M0_A; odi = m_owner ? M1_DI : M0_DI;
      oba = m_owner ? M1_BA : M0_BA; owe = m_owner ? M1_WE : M0_WE;
      exp = {oa, odi, oba, owe, wo,
             (!m_owner && w0) ? rnd_do : 32'd0, w0 && (m_owner || S_BUSY),
             ( m_owner && w1) ? rnd_do : 32'd0, w1 && (!m_owner || S_BUSY),
             m_owner, m_locked};
      check($sformatf("rand%0d", cyc), all_outs(), exp);
      if (CE_R) begin
        if (!RES_N) begin
          m_owner = 0; m_locked = 0; m_budget = 0;
        end else begin
          off = int'(oa - B);
          done = wo && !S_BUSY;
          setl = done && owe && (off == 4 || off == 20);
          rel = done && !owe && (off == 4 || off == 20 || off == 28);
          if (m_locked && EN) begin
            m_budget--;
            if (m_budget == 0) rel = 1;
          end
          if (rel) m_locked = 0;
          if (setl) begin
            m_locked = 1; m_budget = 80;
          end
          if (!m_locked && !wo && woth) m_owner = !m_owner;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
